// File: rtl/m_adder_comparator_counter.sv
// Adder, unsigned magnitude comparator and up/down load counter sharing one clock.
// The adder and comparator are purely combinational; the counter is the only state.

module m_adder #(
  parameter int WIDTH = 14
) (
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin
);
  // Extending to WIDTH+1 bits keeps the carry; Sum wraps naturally.
  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
endmodule

module m_comparator #(
  parameter int WIDTH = 14
) (
  output logic             AltB,
  output logic             AeqB,
  output logic             AgtB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B
);
  assign AltB = (A < B);
  assign AeqB = (A == B);
  assign AgtB = (A > B);
endmodule

module m_counter #(
  parameter int WIDTH = 14
) (
  output logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] D,
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             up,
  input  logic             en
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Priority: clear, then load, then count; direction only matters when counting.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = D;
    end else if (en) begin
      if (up) count_d = count_q + 1'b1;
      else    count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign Q = count_q;
endmodule

module m_adder_comparator_counter #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  input  logic             add_cin,
  output logic [WIDTH-1:0] add_sum,
  output logic             add_cout,
  input  logic [WIDTH-1:0] cmp_a,
  input  logic [WIDTH-1:0] cmp_b,
  output logic             cmp_lt,
  output logic             cmp_eq,
  output logic             cmp_gt,
  input  logic [WIDTH-1:0] cnt_d,
  input  logic             cnt_load,
  input  logic             cnt_up,
  input  logic             cnt_en,
  output logic [WIDTH-1:0] cnt_q
);
  m_adder #(.WIDTH(WIDTH)) u_adder (
    .Sum  (add_sum),
    .Cout (add_cout),
    .A    (add_a),
    .B    (add_b),
    .Cin  (add_cin)
  );

  m_comparator #(.WIDTH(WIDTH)) u_comparator (
    .AltB (cmp_lt),
    .AeqB (cmp_eq),
    .AgtB (cmp_gt),
    .A    (cmp_a),
    .B    (cmp_b)
  );

  m_counter #(.WIDTH(WIDTH)) u_counter (
    .Q    (cnt_q),
    .D    (cnt_d),
    .clk  (clk),
    .clr  (rst),
    .load (cnt_load),
    .up   (cnt_up),
    .en   (cnt_en)
  );
endmodule

// File: tb/tb_m_adder_comparator_counter.sv
// Bench for m_adder_comparator_counter at WIDTH=14 and WIDTH=13: directed cases,
// then random vectors against an arithmetic reference model.

module tb_m_adder_comparator_counter;
  logic clk;
  logic rst;

  logic [13:0] a14, b14, ca14, cb14, d14, sum14, q14;
  logic        cin14, cout14, lt14, eq14, gt14;
  logic [12:0] a13, b13, ca13, cb13, d13, sum13, q13;
  logic        cin13, cout13, lt13, eq13, gt13;
  logic        cnt_load, cnt_up, cnt_en;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  m_adder_comparator_counter #(.WIDTH(14)) dut14 (
    .clk(clk), .rst(rst),
    .add_a(a14), .add_b(b14), .add_cin(cin14), .add_sum(sum14), .add_cout(cout14),
    .cmp_a(ca14), .cmp_b(cb14), .cmp_lt(lt14), .cmp_eq(eq14), .cmp_gt(gt14),
    .cnt_d(d14), .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_en(cnt_en), .cnt_q(q14)
  );

  m_adder_comparator_counter #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst),
    .add_a(a13), .add_b(b13), .add_cin(cin13), .add_sum(sum13), .add_cout(cout13),
    .cmp_a(ca13), .cmp_b(cb13), .cmp_lt(lt13), .cmp_eq(eq13), .cmp_gt(gt13),
    .cnt_d(d13), .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_en(cnt_en), .cnt_q(q13)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference counter step: plain modular arithmetic on integers.
  function automatic longint unsigned cnt_model(input longint unsigned cur, input longint unsigned d,
                                                input int w, input bit r, input bit ld,
                                                input bit en, input bit up);
    longint unsigned m;
    m = longint'(1) << w;
    if (r)       return 0;
    if (ld)      return d % m;
    if (!en)     return cur;
    if (up)      return (cur + 1) % m;
    return (cur + m - 1) % m;
  endfunction

  task automatic check_arith14(input string tag);
    longint unsigned s;
    s = longint'(a14) + longint'(b14) + longint'(cin14);
    check({tag, "_sum"},  {18'd0, sum14}, 32'(s % 16384));
    check({tag, "_cout"}, {31'd0, cout14}, 32'(s / 16384));
    check({tag, "_lt"}, {31'd0, lt14}, {31'd0, (int'(ca14) <  int'(cb14))});
    check({tag, "_eq"}, {31'd0, eq14}, {31'd0, (int'(ca14) == int'(cb14))});
    check({tag, "_gt"}, {31'd0, gt14}, {31'd0, (int'(ca14) >  int'(cb14))});
  endtask

  task automatic check_arith13(input string tag);
    longint unsigned s;
    s = longint'(a13) + longint'(b13) + longint'(cin13);
    check({tag, "_sum"},  {19'd0, sum13}, 32'(s % 8192));
    check({tag, "_cout"}, {31'd0, cout13}, 32'(s / 8192));
    check({tag, "_lt"}, {31'd0, lt13}, {31'd0, (int'(ca13) <  int'(cb13))});
    check({tag, "_eq"}, {31'd0, eq13}, {31'd0, (int'(ca13) == int'(cb13))});
    check({tag, "_gt"}, {31'd0, gt13}, {31'd0, (int'(ca13) >  int'(cb13))});
  endtask

  task automatic ctl(input bit r, input bit ld, input bit en, input bit up, input logic [13:0] d);
    rst = r; cnt_load = ld; cnt_en = en; cnt_up = up; d14 = d; d13 = d[12:0];
  endtask

  initial begin
    longint unsigned m14, m13;
    a14 = '0; b14 = '0; cin14 = 0; ca14 = '0; cb14 = '0;
    a13 = '0; b13 = '0; cin13 = 0; ca13 = '0; cb13 = '0;
    ctl(1, 0, 0, 0, '0);
    #1;

    // Adder directed
    a14 = 14'h3FFF; b14 = 14'h0001; cin14 = 0; #1;
    check("add_wrap_sum", {18'd0, sum14}, 32'h0);
    check("add_wrap_cout", {31'd0, cout14}, 32'h1);
    a14 = 14'd100; b14 = 14'h3FE2; #1;
    check("add_neg_sum", {18'd0, sum14}, 32'd70);
    a14 = 14'h3FFF; b14 = 14'h3FFF; cin14 = 1; #1;
    check("add_max_sum", {18'd0, sum14}, 32'h3FFF);
    check("add_max_cout", {31'd0, cout14}, 32'h1);

    // Comparator directed
    ca14 = 14'd5; cb14 = 14'd5; #1;
    check("cmp_eq_eq", {31'd0, eq14}, 32'd1);
    check("cmp_eq_lt", {31'd0, lt14}, 32'd0);
    check("cmp_eq_gt", {31'd0, gt14}, 32'd0);
    ca14 = 14'h2000; cb14 = 14'h1FFF; #1;
    check("cmp_uns_gt", {31'd0, gt14}, 32'd1);
    check("cmp_uns_lt", {31'd0, lt14}, 32'd0);
    ca14 = 14'h0; cb14 = 14'h3FFF; #1;
    check("cmp_min_lt", {31'd0, lt14}, 32'd1);
    check("cmp_min_eq", {31'd0, eq14}, 32'd0);

    // Counter up / hold
    tick();
    check("cnt_reset", {18'd0, q14}, 32'd0);
    ctl(0, 0, 1, 1, 14'd0);
    repeat (5) tick();
    check("cnt_up5", {18'd0, q14}, 32'd5);
    ctl(0, 0, 0, 1, 14'd0);
    repeat (3) tick();
    check("cnt_hold", {18'd0, q14}, 32'd5);
    cnt_up = 0;
    tick();
    check("cnt_hold_dn", {18'd0, q14}, 32'd5);

    // Down / wrap
    ctl(0, 1, 0, 0, 14'd1); tick();
    check("cnt_load1", {18'd0, q14}, 32'd1);
    ctl(0, 0, 1, 0, 14'd0); tick();
    check("cnt_dn0", {18'd0, q14}, 32'd0);
    tick();
    check("cnt_dn_wrap", {18'd0, q14}, 32'h3FFF);
    ctl(0, 1, 0, 0, 14'h3FFF); tick();
    check("cnt_load_max", {18'd0, q14}, 32'h3FFF);
    ctl(0, 0, 1, 1, 14'd0); tick();
    check("cnt_up_wrap", {18'd0, q14}, 32'd0);

    // Priority
    ctl(0, 1, 1, 0, 14'd42); tick();
    check("cnt_load_wins", {18'd0, q14}, 32'd42);
    ctl(1, 1, 1, 1, 14'd42); tick();
    check("cnt_rst_wins", {18'd0, q14}, 32'd0);

    // Reset mid-count then resume
    ctl(0, 0, 1, 1, 14'd0); repeat (3) tick();
    check("cnt_pre_rst", {18'd0, q14}, 32'd3);
    rst = 1; tick();
    check("cnt_mid_rst", {18'd0, q14}, 32'd0);
    rst = 0; tick();
    check("cnt_resume", {18'd0, q14}, 32'd1);

    // Random adder/comparator at both widths; rst toggled to show it has no effect
    for (int i = 0; i < 1000; i++) begin
      rst = 1'($urandom_range(0, 1));
      a14 = 14'($urandom); b14 = 14'($urandom); cin14 = 1'($urandom);
      a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        ca14 = 14'($urandom); cb14 = ca14; ca13 = 13'($urandom); cb13 = ca13;
      end else begin
        ca14 = 14'($urandom); cb14 = 14'($urandom); ca13 = 13'($urandom); cb13 = 13'($urandom);
      end
      #1;
      check_arith14("rnd14");
      check_arith13("rnd13");
    end

    // Random counter sequences at both widths, expectations queued one edge ahead
    ctl(1, 0, 0, 0, '0); tick();
    m14 = 0; m13 = 0;
    for (int i = 0; i < 400; i++) begin
      ctl(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) == 0),
          1'($urandom), 1'($urandom),
          ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom));
      m14 = cnt_model(m14, longint'(d14), 14, rst, cnt_load, cnt_en, cnt_up);
      m13 = cnt_model(m13, longint'(d13), 13, rst, cnt_load, cnt_en, cnt_up);
      exp_q.push_back(32'(m14));
      exp_q.push_back(32'(m13));
      tick();
      check("rnd_cnt14", {18'd0, q14}, exp_q.pop_front());
      check("rnd_cnt13", {19'd0, q13}, exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
